// File: rtl/led_arbiter.sv
// led_arbiter: round-robin owner of a shared 4-bit LED bank among three
// requesters. An owner keeps the bank for at least DWELL cycles while its
// request stays high. A voluntary release forces a one-cycle GAP before
// the next IDLE arbitration. Grant is registered and is one-hot or zero.
module led_arbiter #(
  parameter int unsigned DWELL    = 50000000,
  parameter logic [3:0]  IDLE_PAT = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [3:0] pat0,
  input  logic [3:0] pat1,
  input  logic [3:0] pat2,
  output logic [2:0] grant,
  output logic [3:0] led,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // The dwell counter counts DWELL-1 down to 0.
  // It reads 0 once the owner has held the bank for DWELL cycles.
  localparam logic [25:0] RELOAD = 26'(DWELL - 1);

  state_t      state_q;
  logic [2:0]  grant_q;
  logic [25:0] cnt_q;
  logic [1:0]  last_q;

  logic [1:0]  start_d;
  logic [2:0]  cand_d;
  logic [1:0]  win_d;
  logic        win_vld_d;
  logic        expired_d;

  // First candidate found from start, searching upward and wrapping modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(start) + k) % 3);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Compute the round-robin winner. The search starts just past the last owner.
  // While in OWN, the owner is masked out, so a handoff always goes to someone else.
  always_comb begin
    start_d   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    cand_d    = (state_q == S_OWN) ? (req & ~grant_q) : req;
    {win_vld_d, win_d} = rr_pick(cand_d, start_d);
    expired_d = (cnt_q == 26'd0);
  end

  // Arbitration FSM. State, grant, dwell counter and last owner are all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      cnt_q   <= 26'd0;
      last_q  <= 2'd2;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            grant_q <= 3'b001 << win_d;
            last_q  <= win_d;
            cnt_q   <= RELOAD;
            state_q <= S_OWN;
          end
        end
        S_OWN: begin
          if (!req[last_q]) begin
            // A voluntary release always takes the gap.
            // This holds even if the counter expires on the same edge.
            grant_q <= 3'b000;
            state_q <= S_GAP;
          end else if (expired_d && win_vld_d) begin
            grant_q <= 3'b001 << win_d;
            last_q  <= win_d;
            cnt_q   <= RELOAD;
          end else if (!expired_d) begin
            cnt_q <= cnt_q - 26'd1;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 3'b000;
        end
      endcase
    end
  end

  // Route the owner's pattern to the LEDs. Show IDLE_PAT when no one holds the bank.
  always_comb begin
    led = IDLE_PAT;
    case (grant_q)
      3'b001:  led = pat0;
      3'b010:  led = pat1;
      3'b100:  led = pat2;
      default: led = IDLE_PAT;
    endcase
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with DWELL=4 and IDLE_PAT=1001.
module tb_led_arbiter;
  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [3:0] pat0, pat1, pat2;
  logic [2:0] grant;
  logic [3:0] led;
  logic       busy;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] IP = 4'b1001;

  led_arbiter #(.DWELL(4), .IDLE_PAT(4'b1001)) dut (
    .clk(clk), .reset(reset), .req(req), .pat0(pat0), .pat1(pat1), .pat2(pat2),
    .grant(grant), .led(led), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [3:0] l);
    chk({tag, ".grant"}, {1'b0, grant}, {1'b0, g});
    chk({tag, ".led"}, led, l);
    chk({tag, ".busy"}, {3'b000, busy}, {3'b000, |g});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = 3'b000;
    pat0 = 4'b0001; pat1 = 4'b0110; pat2 = 4'b1100;
    tick();
    chk_out("reset", 3'b000, IP);
    reset = 1'b0;

    // IDLE with no request holds.
    tick();
    chk_out("idle_hold", 3'b000, IP);

    // Full rotation with all requesters asking.
    req = 3'b111;
    tick();                                   // edge 1
    chk_out("rot_e1", 3'b001, 4'b0001);
    tick(); tick(); tick();                   // edges 2..4
    chk_out("rot_e4", 3'b001, 4'b0001);
    tick();                                   // edge 5
    chk_out("rot_e5", 3'b010, 4'b0110);
    tick(); tick(); tick();                   // edge 8
    chk_out("rot_e8", 3'b010, 4'b0110);
    tick();                                   // edge 9
    chk_out("rot_e9", 3'b100, 4'b1100);
    tick(); tick(); tick(); tick();           // edge 13
    chk_out("rot_e13", 3'b001, 4'b0001);

    // Lone requester keeps the bank. A later request preempts at once.
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk({"solo.grant"}, {1'b0, grant}, 4'b0010);
    end
    req = 3'b011;
    tick();
    chk_out("preempt", 3'b001, 4'b0001);

    // The LEDs follow the owner's pattern combinationally. Other patterns are ignored.
    pat0 = 4'b0010;
    #1;
    chk("pat0_track", led, 4'b0010);
    pat1 = 4'b1111; pat2 = 4'b0000;
    #1;
    chk("pat_other", led, 4'b0010);

    // A voluntary release gives two cycles of zero grant, then the waiter is granted.
    do_reset();
    req = 3'b101;
    tick();
    chk_out("rel_own", 3'b001, 4'b0010);
    req = 3'b100;
    tick();
    chk_out("rel_gap", 3'b000, IP);
    tick();
    chk_out("rel_idle", 3'b000, IP);
    tick();
    chk_out("rel_next", 3'b100, 4'b0000);

    // An asynchronous reset between edges clears the grant immediately.
    #3;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 3'b000, IP);
    req = 3'b111;
    @(posedge clk); #1;
    reset = 1'b0;
    tick();                                   // edge 1
    chk_out("post_rst", 3'b001, 4'b0010);

    // The owner drops its request on the same edge its dwell expires, so the gap is taken.
    tick(); tick(); tick();                   // edges 2..4, counter reaches 0
    req = 3'b110;
    tick();
    chk_out("exp_drop_gap", 3'b000, IP);
    tick();
    chk_out("exp_drop_idle", 3'b000, IP);
    tick();
    chk_out("exp_drop_next", 3'b010, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
